piso_tx: RTL

Parallel-in serial-out transmitter. It is the sending end for the team's serial shift-register chain (siso/sipo receivers).
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Shifts the word out one bit per clock on q/qbar, with a frame strobe.
- Inserts a programmable idle gap between words.
- Sits between a parallel producer and a serial link.

---
 rtl/piso_tx.sv | 113 +++++++++++
 1 files changed

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a word over valid/ready and
// shifts it out one bit per clock on q/qbar with a frame strobe and idle gap.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             ready,
  output logic             q,
  output logic             qbar,
  output logic             frame,
  output logic             done
);

  // state   | meaning
  // S_IDLE  | waiting for a word, ready high, q low
  // S_SHIFT | q carries data bit bitcnt of the current word
  // S_GAP   | idle gap after a word, ready low, q low

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]     GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bitcnt;
  logic [3:0]       gapcnt;
  logic             last_bit;
  logic             accept;

  function automatic logic first_of(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_of(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign last_bit = (state == S_SHIFT) && (bitcnt == LAST_BIT);
  // With no gap the next word may be taken during the final bit so frame stays continuous.
  assign ready    = (state == S_IDLE) || ((GAP == 0) && last_bit);
  assign accept   = load_valid && ready;
  assign qbar     = ~q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      sreg   <= '0;
      bitcnt <= '0;
      gapcnt <= '0;
      q      <= 1'b0;
      frame  <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            q      <= first_of(din);
            sreg   <= shift_of(din);
            bitcnt <= '0;
            frame  <= 1'b1;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bitcnt == LAST_BIT) begin
            done <= 1'b1;
            if (accept) begin
              q      <= first_of(din);
              sreg   <= shift_of(din);
              bitcnt <= '0;
            end else begin
              q      <= 1'b0;
              frame  <= 1'b0;
              sreg   <= '0;
              bitcnt <= '0;
              if (GAP > 0) begin
                gapcnt <= GAP_LOAD;
                state  <= S_GAP;
              end else begin
                state  <= S_IDLE;
              end
            end
          end else begin
            q      <= first_of(sreg);
            sreg   <= shift_of(sreg);
            bitcnt <= bitcnt + CW'(1);
          end
        end
        S_GAP: begin
          if (gapcnt == 4'd0) begin
            state <= S_IDLE;
          end else begin
            gapcnt <= gapcnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
